md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//   Multi-cycle multiply/divide controller with the HI/LO register pair, in the E stage of the 5-stage MIPS pipeline.
//   Accepts a decoded MD op from E, computes the result once, then holds busy for a fixed latency.
//   Commits HI/LO at the end of the latency window.
//   Generates the stall request that freezes the D stage when the D-stage instruction needs the MD unit.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD/MSUB when enabled)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU
// PORTS
//   clk       in   1   single clock, rising edge
//   rst_n     in   1   synchronous, active-low reset
//   start     in   1   E-stage instruction is a valid MD op this cycle
//   op        in   3   MD op code (md_pkg encodings)
//   a         in   32  rs operand (forwarded)
//   b         in   32  rt operand (forwarded)
//   md_in_d   in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//   busy      out  1   MD unit occupied (registered)
//   stall     out  1   = md_in_d & (busy | start_mul_div); combinational
//   hi        out  32  HI register
//   lo        out  32  LO register
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): hi=0, lo=0, busy=0, counter=0, state IDLE.
//     Reset aborts any in-flight op; no commit.
//   States: IDLE, RUN.
//   IDLE, start & op in {MULT,MULTU,DIV,DIVU} -> RUN.
//     Operands are sampled and the result is computed into pending_hi/pending_lo.
//     cnt <= N-1, with N = MULT_CYCLES or DIV_CYCLES.
//   RUN: busy=1; cnt decrements each cycle.
//     At cnt==0: hi/lo <= pending; -> IDLE.
//   Latency: start at cycle t -> busy=1 in cycles t+1..t+N; new hi/lo visible at t+N+1.
//   MTHI/MTLO in IDLE: hi (or lo) <= a at the same edge. No busy.
//   start while RUN: ignored entirely; pipeline stall guarantees this never happens legally.
//   MULT/DIV are signed; MULTU/DIVU are unsigned.
//     Mult: {hi,lo} = 64-bit product.
//     Div: lo = quotient, hi = remainder; quotient truncates toward zero, remainder takes the dividend's sign.
//   Divide by zero (b==0): busy sequence as normal; hi/lo keep prior values at commit.
//   DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wrap, no trap).
//   start_mul_div = start & op in {MULT,MULTU,DIV,DIVU[,MADD,MADDU,MSUB,MSUBU]}.
//   Last busy cycle (cnt==0): stall is still asserted, so mfhi/mflo in D reads the new value one cycle later.
// CONFIGURATION
//   MD_MADD_EN defined: adds ops MADD, MADDU, MSUB, MSUBU.
//     Result: {hi,lo} <= {hi,lo} +/- product, using the hi/lo value captured at start.
//     Latency: MULT_CYCLES.
//   MD_MADD_EN undefined: those encodings are treated as no-op; no busy, no state change.
// STRUCTURE
//   md_pkg holds:
//     op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MADD=6, MD_MSUB=7.
//     MADDU/MSUBU: op=6/7 with b[31] handled via an unsigned flag bit if widened.
//     state encodings IDLE/RUN.
//     Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)).
//   Sub-module md_alu (combinational): op, a, b, hi, lo -> pending_hi, pending_lo. md_ctrl owns all state and the counter.
// TESTING
//   Reset: hold rst_n=0 during RUN of a DIV -> busy=0, hi=lo=0 next cycle; no later commit.
//   MULT a=0xFFFFFFFE(-2), b=3:
//     busy high exactly 5 cycles.
//     Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
//   DIV a=-7, b=2:
//     busy 10 cycles.
//     lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     DIVU 7/0 -> hi/lo unchanged after 10 busy cycles.
//   Stall:
//     md_in_d=1 in the start cycle and every busy cycle -> stall=1.
//     md_in_d=1 in the cycle after busy falls -> stall=0.
//     md_in_d=0 -> stall=0 throughout.
//   MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0.
//     MTHI during RUN -> ignored.
//     start of DIV during RUN -> ignored; original result commits on time.
//   MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles.
//     Without the macro: same stimulus -> no busy, hi/lo unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings, default latencies.
// Optional feature macro: MD_MADD_EN enables MADD/MSUB accumulate ops.
package md_pkg;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W = $clog2((MD_MULT_CYCLES > MD_DIV_CYCLES) ? MD_MULT_CYCLES : MD_DIV_CYCLES);

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle window.
    function automatic logic is_long_op(input logic [2:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MSUB:                   r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath producing the HI/LO values to commit.
// Optional feature macro: MD_MADD_EN enables MADD/MSUB accumulation onto HI/LO.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pending_hi,
    output logic [31:0] pending_lo
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               div_zero;
    logic               div_ovf;

    // Result selection; divide-by-zero leaves HI/LO as they were.
    always_comb begin
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        div_zero = (b == 32'd0);
        div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        div_b    = div_zero ? 32'd1 : b;
        quo_s    = div_ovf ? 32'sh8000_0000 : $signed(a) / $signed(div_b);
        rem_s    = div_ovf ? 32'sd0 : $signed(a) % $signed(div_b);
        quo_u    = a / div_b;
        rem_u    = a % div_b;
        pending_hi = hi;
        pending_lo = lo;
        case (op)
            MD_MULT:  {pending_hi, pending_lo} = prod_s;
            MD_MULTU: {pending_hi, pending_lo} = prod_u;
            MD_DIV: begin
                if (!div_zero) begin
                    pending_hi = rem_s;
                    pending_lo = quo_s;
                end else begin
                    pending_hi = hi;
                    pending_lo = lo;
                end
            end
            MD_DIVU: begin
                if (!div_zero) begin
                    pending_hi = rem_u;
                    pending_lo = quo_u;
                end else begin
                    pending_hi = hi;
                    pending_lo = lo;
                end
            end
`ifdef MD_MADD_EN
            // The 3-bit op has no room for an unsigned flag, so accumulates use the signed product.
            MD_MADD:  {pending_hi, pending_lo} = {hi, lo} + prod_s;
            MD_MSUB:  {pending_hi, pending_lo} = {hi, lo} - prod_s;
`endif
            default: begin
                pending_hi = hi;
                pending_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and D-stage stall generation.
// Optional feature macro: MD_MADD_EN adds MADD/MSUB ops with MULT latency.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_r, state_next;
    logic [CNT_W-1:0] cnt_r, cnt_next;
    logic [31:0]      hi_r, hi_next, lo_r, lo_next;
    logic [31:0]      pend_hi_r, pend_hi_next, pend_lo_r, pend_lo_next;
    logic [31:0]      alu_hi, alu_lo;
    logic             busy_r, busy_next;
    logic             start_mul_div;

    md_alu u_alu (
        .op         (op),
        .a          (a),
        .b          (b),
        .hi         (hi_r),
        .lo         (lo_r),
        .pending_hi (alu_hi),
        .pending_lo (alu_lo)
    );

    assign start_mul_div = start & is_long_op(op);
    assign stall         = md_in_d & (busy_r | start_mul_div);
    assign busy          = busy_r;
    assign hi            = hi_r;
    assign lo            = lo_r;

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_next   = state_r;
        cnt_next     = cnt_r;
        hi_next      = hi_r;
        lo_next      = lo_r;
        pend_hi_next = pend_hi_r;
        pend_lo_next = pend_lo_r;
        case (state_r)
            IDLE: begin
                if (start_mul_div) begin
                    state_next   = RUN;
                    cnt_next     = is_div_op(op) ? DIV_LAST : MULT_LAST;
                    pend_hi_next = alu_hi;
                    pend_lo_next = alu_lo;
                end else if (start && (op == MD_MTHI)) begin
                    hi_next = a;
                end else if (start && (op == MD_MTLO)) begin
                    lo_next = a;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == '0) begin
                    state_next = IDLE;
                    hi_next    = pend_hi_r;
                    lo_next    = pend_lo_r;
                end else begin
                    cnt_next = cnt_r - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next;
            cnt_r     <= cnt_next;
            hi_r      <= hi_next;
            lo_r      <= lo_next;
            pend_hi_r <= pend_hi_next;
            pend_lo_r <= pend_lo_next;
            busy_r    <= busy_next;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus random traffic against a behavioural model.
// Honors MD_MADD_EN the same way as the design.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        md_in_d = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;

    md_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .md_in_d(md_in_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_long(input logic [2:0] o);
`ifdef MD_MADD_EN
        return 1'b1 ? (o != 3'd4 && o != 3'd5) : 1'b0;
`else
        return o <= 3'd3;
`endif
    endfunction

    function automatic int m_latency(input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3) ? 10 : 5;
    endfunction

    // Model of one rising edge using the currently driven inputs.
    task automatic model_edge();
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        if (!rst_n) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (start) begin
            if (op == 3'd1 || op == 3'd3) begin
                sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
            end else begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
            end
            m_phi = m_hi; m_plo = m_lo;
            p = sa * sb;
            if (op <= 3'd1) begin
                m_phi = p[63:32]; m_plo = p[31:0];
            end else if (op <= 3'd3) begin
                if (b != 32'd0) begin
                    q = sa / sb; r = sa - q * sb;
                    m_plo = q[31:0]; m_phi = r[31:0];
                end
            end else if (op == 3'd4) begin
                m_hi = a;
            end else if (op == 3'd5) begin
                m_lo = a;
            end else begin
`ifdef MD_MADD_EN
                acc = (op == 3'd6) ? ({m_hi, m_lo} + p) : ({m_hi, m_lo} - p);
                m_phi = acc[63:32]; m_plo = acc[31:0];
`endif
            end
            if (m_is_long(op)) m_left = m_latency(op);
        end
    endtask

    // One cycle with the currently driven inputs; checks stall before the edge and state after it.
    task automatic step();
        #1;
        check("stall", {63'd0, stall}, {63'd0, md_in_d & ((m_left > 0) | (start & m_is_long(op)))});
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    // Issue one op, then run until busy falls (bounded); returns the busy length.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic md, output int len);
        start = 1'b1; op = o; a = va; b = vb; md_in_d = md;
        step();
        start = 1'b0;
        len = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            len++;
            step();
        end
    endtask

    initial begin
        int len;
        rst_n = 1'b0;
        step(); step();
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        step();

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, len);
        check("mult_len", 64'(len), 64'd5);
        check("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
        step();
        check("stall_after", {63'd0, stall}, 64'd0);
        md_in_d = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, len);
        check("multu_hi", {32'd0, hi}, 64'h2);
        check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, len);
        check("div_len", 64'(len), 64'd10);
        check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        run_op(3'd3, 32'd7, 32'd0, 1'b0, len);
        check("div0_len", 64'(len), 64'd10);
        check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div0_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        run_op(3'd5, 32'h1234, 32'd0, 1'b0, len);
        check("mtlo_len", 64'(len), 64'd0);
        check("mtlo_lo", {32'd0, lo}, 64'h1234);

        // Ops arriving while RUN must be ignored.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7; step();
        op = 3'd4; a = 32'hDEAD_BEEF; step();
        op = 3'd2; a = 32'd50; b = 32'd3; step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("ign_lo", {32'd0, lo}, 64'd14);
        check("ign_hi", {32'd0, hi}, 64'd2);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, len);
        check("ovf_lo", {32'd0, lo}, 64'h8000_0000);
        check("ovf_hi", {32'd0, hi}, 64'd0);

        run_op(3'd4, 32'd0, 32'd0, 1'b0, len);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, len);
        run_op(3'd6, 32'd1, 32'd1, 1'b1, len);
`ifdef MD_MADD_EN
        check("madd_len", 64'(len), 64'd5);
        check("madd_hi", {32'd0, hi}, 64'd1);
        check("madd_lo", {32'd0, lo}, 64'd0);
`else
        check("madd_len", 64'(len), 64'd0);
        check("madd_hi", {32'd0, hi}, 64'd0);
        check("madd_lo", {32'd0, lo}, 64'hFFFF_FFFF);
`endif

        // Reset in the middle of a divide: no commit afterwards.
        run_op(3'd5, 32'h55AA, 32'd0, 1'b0, len);
        start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd4; step();
        start = 1'b0; step(); step();
        rst_n = 1'b0; step();
        check("rst_run_busy", {63'd0, busy}, 64'd0);
        check("rst_run_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("rst_nocommit_lo", {32'd0, lo}, 64'd0);
        check("rst_nocommit_hi", {32'd0, hi}, 64'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            md_in_d = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
